// File: rtl/pc_ctrl_pkg.sv
// Shared fetch-path definitions: bus types, reset vector, NOP encoding and
// the fetch-control state encodings.
package pc_ctrl_pkg;

   localparam int Wordnum = 32;

   typedef logic [Wordnum-1:0] InstBus;
   typedef logic [Wordnum-1:0] InstAddrBus;

   localparam InstBus     INST_NOP     = 32'h0000_0013;
   localparam InstAddrBus RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      PCC_BOOT  = 2'd0,
      PCC_RUN   = 2'd1,
      PCC_STALL = 2'd2
   } pcc_state_e;

   function automatic InstAddrBus word_align(input InstAddrBus addr);
      return {addr[Wordnum-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_ctrl_dff.sv
// Clock-enabled register with synchronous active-low load of a set value.
module pc_ctrl_dff #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_ce,
   input  logic [W-1:0] i_set_data,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn)
         r_q <= i_set_data;
      else if (i_ce)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch control: owns the PC, drives instruction-memory address/enable and
// steers IF between live memory data and its captured copy during stalls.
//
//   state     | meaning
//   PCC_BOOT  | post-reset bubble, fetching RESET_PC, nothing valid yet
//   PCC_RUN   | streaming; IF presents live mem_rdata
//   PCC_STALL | downstream held; IF replays its captured instruction
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter InstAddrBus RESET_PC = RESET_PC_DEF
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       hold,
   input  logic       jump_en,
   input  InstBus     jump_addr,
   output InstBus     mem_addr,
   output logic       mem_ren,
   output logic       inst_CE,
   output logic       inst_sel,
   output InstBus     pc,
   output logic       inst_valid
);

   pcc_state_e r_state;
   pcc_state_e w_state_nxt;
   InstAddrBus w_pc_q;
   InstAddrBus w_seq;
   InstAddrBus w_jmp_tgt;
   InstAddrBus w_pc_d;
   logic       w_pc_ce;

   assign w_seq     = w_pc_q + 32'd4;
   assign w_jmp_tgt = word_align(jump_addr);

   always_ff @(posedge clk) begin
      if (!rstn)
         r_state <= PCC_BOOT;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_ce     = 1'b0;
      w_pc_d      = w_seq;
      if (jump_en) begin
         w_state_nxt = PCC_RUN;
         w_pc_ce     = 1'b1;
         w_pc_d      = w_jmp_tgt;
      end else begin
         case (r_state)
            PCC_BOOT:  w_state_nxt = PCC_RUN;
            PCC_RUN: begin
               if (hold) begin
                  w_state_nxt = PCC_STALL;
               end else begin
                  w_pc_ce = 1'b1;
               end
            end
            PCC_STALL: begin
               if (!hold) begin
                  w_state_nxt = PCC_RUN;
                  w_pc_ce     = 1'b1;
               end
            end
            default:   w_state_nxt = PCC_BOOT;
         endcase
      end
   end

   // A redirect overrides whatever the current state would present.
   always_comb begin
      mem_addr   = w_pc_q;
      mem_ren    = 1'b1;
      inst_valid = 1'b0;
      inst_CE    = 1'b0;
      inst_sel   = 1'b0;
      if (jump_en) begin
         mem_addr = w_jmp_tgt;
      end else begin
         case (r_state)
            PCC_RUN: begin
               mem_addr   = w_seq;
               mem_ren    = !hold;
               inst_valid = 1'b1;
               inst_CE    = hold;
            end
            PCC_STALL: begin
               mem_addr   = w_seq;
               mem_ren    = !hold;
               inst_valid = 1'b1;
               inst_sel   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   pc_ctrl_dff #(.W(Wordnum)) u_pc_reg (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_ce       (w_pc_ce),
      .i_set_data (RESET_PC),
      .i_d        (w_pc_d),
      .o_q        (w_pc_q)
   );

   assign pc = w_pc_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus pushes hand-computed per-cycle
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_pc_ctrl;

   logic        clk;
   logic        rstn;
   logic        hold;
   logic        jump_en;
   logic [31:0] jump_addr;

   logic [31:0] mem_addr, pc;
   logic        mem_ren, inst_CE, inst_sel, inst_valid;
   logic [31:0] mem_addr2, pc2;
   logic        mem_ren2, inst_CE2, inst_sel2, inst_valid2;

   typedef struct {
      logic [31:0] addr;
      logic        ren;
      logic        ce;
      logic        sel;
      logic [31:0] pc;
      logic        valid;
      bit          chk2;
      logic [31:0] pc2;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_id  = 0;

   pc_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rstn(rstn), .hold(hold), .jump_en(jump_en),
      .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_ren(mem_ren),
      .inst_CE(inst_CE), .inst_sel(inst_sel), .pc(pc), .inst_valid(inst_valid)
   );

   pc_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .rstn(rstn), .hold(hold), .jump_en(jump_en),
      .jump_addr(jump_addr), .mem_addr(mem_addr2), .mem_ren(mem_ren2),
      .inst_CE(inst_CE2), .inst_sel(inst_sel2), .pc(pc2), .inst_valid(inst_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (mem_addr !== e.addr || mem_ren !== e.ren || inst_CE !== e.ce ||
             inst_sel !== e.sel || pc !== e.pc || inst_valid !== e.valid) begin
            failures++;
            $display("FAIL step%0d outputs: got addr=%h ren=%b ce=%b sel=%b pc=%h valid=%b, want addr=%h ren=%b ce=%b sel=%b pc=%h valid=%b",
                     e.id, mem_addr, mem_ren, inst_CE, inst_sel, pc, inst_valid,
                     e.addr, e.ren, e.ce, e.sel, e.pc, e.valid);
         end
         if (e.chk2) begin
            checks++;
            if (pc2 !== e.pc2) begin
               failures++;
               $display("FAIL step%0d wrap_pc: got %h want %h", e.id, pc2, e.pc2);
            end
         end
      end
   end

   task automatic step(input logic r, input logic h, input logic j,
                       input logic [31:0] ja, input logic [31:0] ea,
                       input logic er, input logic ec, input logic es,
                       input logic [31:0] ep, input logic ev,
                       input bit c2, input logic [31:0] ep2);
      exp_t e;
      rstn      = r;
      hold      = h;
      jump_en   = j;
      jump_addr = ja;
      e.addr = ea; e.ren = er; e.ce = ec; e.sel = es;
      e.pc = ep; e.valid = ev; e.chk2 = c2; e.pc2 = ep2; e.id = step_id;
      sb_q.push_back(e);
      step_id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = '0;
      @(posedge clk);
      #1;
      //    rstn hold jmp jaddr         addr          ren ce sel pc            v  c2 pc2
      step(0, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0, 32'h0000_0000, 0, 1, 32'hFFFF_FFF8);
      step(1, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0, 32'h0000_0000, 0, 1, 32'hFFFF_FFF8);
      step(1, 0, 0, 32'h0,          32'h0000_0004, 1, 0, 0, 32'h0000_0000, 1, 1, 32'hFFFF_FFF8);
      step(1, 0, 0, 32'h0,          32'h0000_0008, 1, 0, 0, 32'h0000_0004, 1, 1, 32'hFFFF_FFFC);
      // three-cycle hold at pc=8
      step(1, 1, 0, 32'h0,          32'h0000_000C, 0, 1, 0, 32'h0000_0008, 1, 1, 32'h0000_0000);
      step(1, 1, 0, 32'h0,          32'h0000_000C, 0, 0, 1, 32'h0000_0008, 1, 0, 32'h0);
      step(1, 1, 0, 32'h0,          32'h0000_000C, 0, 0, 1, 32'h0000_0008, 1, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_000C, 1, 0, 1, 32'h0000_0008, 1, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0010, 1, 0, 0, 32'h0000_000C, 1, 0, 32'h0);
      // redirect to misaligned 0x103 at pc=0x10
      step(1, 0, 1, 32'h0000_0103,  32'h0000_0100, 1, 0, 0, 32'h0000_0010, 0, 0, 32'h0);
      step(1, 1, 0, 32'h0,          32'h0000_0104, 0, 1, 0, 32'h0000_0100, 1, 0, 32'h0);
      // jump and hold together in STALL
      step(1, 1, 1, 32'h0000_0203,  32'h0000_0200, 1, 0, 0, 32'h0000_0100, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0204, 1, 0, 0, 32'h0000_0200, 1, 0, 32'h0);
      step(1, 1, 0, 32'h0,          32'h0000_0208, 0, 1, 0, 32'h0000_0204, 1, 0, 32'h0);
      // reset mid-stall
      step(0, 1, 0, 32'h0,          32'h0000_0208, 0, 0, 1, 32'h0000_0204, 1, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0, 32'h0000_0000, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0004, 1, 0, 0, 32'h0000_0000, 1, 0, 32'h0);
      // redirect to top of memory then wrap
      step(1, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 1, 0, 0, 32'h0000_0004, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h0);
      step(1, 0, 0, 32'h0,          32'h0000_0004, 1, 0, 0, 32'h0000_0000, 1, 0, 32'h0);

      repeat (3) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
